// File: rtl/qc_ucode_pkg.sv
// Microcode instruction format shared by the sequencer, the gate engine and the bench.
// Layout: opcode[31:28] qa[27:24] qb[23:20] imm[19:4] rsvd[3:0].
package qc_ucode_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned OPC_LSB = 28;
  localparam int unsigned QA_LSB  = 24;
  localparam int unsigned QB_LSB  = 20;
  localparam int unsigned IMM_LSB = 4;
  // REPEAT operands live inside imm: target = imm[15:8], count = imm[7:0].
  localparam int unsigned RPT_CNT_LSB = IMM_LSB;
  localparam int unsigned RPT_TGT_LSB = IMM_LSB + 8;

  typedef enum logic [3:0] {
    OpNop       = 4'h0,
    OpH         = 4'h1,
    OpX         = 4'h2,
    OpZ         = 4'h3,
    OpCnot      = 4'h4,
    OpCphase    = 4'h5,
    OpSwap      = 4'h6,
    OpMaskphase = 4'h7,
    OpRepeat    = 4'hE,
    OpEnd       = 4'hF
  } opcode_e;

  typedef struct packed {
    opcode_e     opcode;
    logic [3:0]  qa;
    logic [3:0]  qb;
    logic [15:0] imm;
    logic [3:0]  rsvd;
  } instr_t;

  function automatic instr_t pack_instr(input opcode_e op, input logic [3:0] qa,
                                        input logic [3:0] qb, input logic [15:0] imm);
    instr_t w;
    w.opcode = op;
    w.qa     = qa;
    w.qb     = qb;
    w.imm    = imm;
    w.rsvd   = 4'h0;
    return w;
  endfunction

  function automatic instr_t pack_repeat(input logic [7:0] target, input logic [7:0] count);
    return pack_instr(OpRepeat, 4'h0, 4'h0, {target, count});
  endfunction

endpackage

// File: rtl/mcseq_prog_ram.sv
// Program store: simple dual-port synchronous RAM, one-cycle read latency, read-first.
// Contents are deliberately not reset.
module mcseq_prog_ram #(
  parameter int unsigned DEPTH = 512,
  parameter int unsigned WIDTH = 32,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Non-blocking read and write in one block give old data on a same-address collision.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/microcode_sequencer.sv
// Multi-slot microcode store with fetch/decode/issue sequencer over a valid/ready port.
// Define MCSEQ_LOOP_EN to build single-level REPEAT loop support (opcode 0xE).
module microcode_sequencer
  import qc_ucode_pkg::*;
#(
  parameter int unsigned NUM_PROGS  = 8,
  parameter int unsigned PROG_DEPTH = 64,
  parameter int unsigned INSTR_W    = qc_ucode_pkg::INSTR_W,
  parameter int unsigned PROG_W     = $clog2(NUM_PROGS),
  parameter int unsigned ADDR_W     = $clog2(PROG_DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [PROG_W-1:0]  wr_prog,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [INSTR_W-1:0] wr_data,
  output logic               wr_err,
  input  logic               start,
  input  logic [PROG_W-1:0]  prog_id,
  input  logic               abort,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr_data,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic [15:0]        issue_cnt
);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StFetch  = 3'd1;
  localparam logic [2:0] StDecode = 3'd2;
  localparam logic [2:0] StIssue  = 3'd3;
  localparam logic [2:0] StDone   = 3'd4;

  localparam logic [ADDR_W-1:0] LastPc = ADDR_W'(PROG_DEPTH - 1);

  logic [2:0]         state_q, state_d;
  logic [PROG_W-1:0]  slot_q, slot_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               err_q, err_d;
  logic [15:0]        cnt_q, cnt_d;
  logic               wr_err_q;
  logic               wr_block;
  logic               handshake;
  logic [INSTR_W-1:0] rd_data;
  logic [3:0]         rd_opcode;

`ifdef MCSEQ_LOOP_EN
  logic               loop_active_q, loop_active_d;
  logic [7:0]         loop_cnt_q, loop_cnt_d;
  logic [ADDR_W-1:0]  rpt_target;
  logic [7:0]         rpt_count;

  assign rpt_target = rd_data[RPT_TGT_LSB +: ADDR_W];
  assign rpt_count  = rd_data[RPT_CNT_LSB +: 8];
`endif

  assign rd_opcode = rd_data[OPC_LSB +: 4];

  assign busy        = (state_q == StFetch) || (state_q == StDecode) || (state_q == StIssue);
  assign instr_valid = (state_q == StIssue);
  assign done        = (state_q == StDone);
  assign err         = done & err_q;
  assign instr_data  = instr_q;
  assign instr_pc    = pc_q;
  assign issue_cnt   = cnt_q;
  assign wr_err      = wr_err_q;

  // The running slot is write-protected so the program cannot change under the sequencer.
  assign wr_block  = wr_en && busy && (wr_prog == slot_q);
  assign handshake = (state_q == StIssue) && instr_ready;

  mcseq_prog_ram #(
    .DEPTH (NUM_PROGS * PROG_DEPTH),
    .WIDTH (INSTR_W),
    .AW    (PROG_W + ADDR_W)
  ) u_prog_ram (
    .clk   (clk),
    .we    (wr_en && !wr_block),
    .waddr ({wr_prog, wr_addr}),
    .wdata (wr_data),
    .raddr ({slot_q, pc_q}),
    .rdata (rd_data)
  );

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
`ifdef MCSEQ_LOOP_EN
    loop_active_d = loop_active_q;
    loop_cnt_d    = loop_cnt_q;
`endif

    if (handshake && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StFetch;
          slot_d  = prog_id;
          pc_d    = '0;
          cnt_d   = '0;
          err_d   = 1'b0;
`ifdef MCSEQ_LOOP_EN
          loop_active_d = 1'b0;
          loop_cnt_d    = '0;
`endif
        end
      end
      StFetch: state_d = StDecode;
      StDecode: begin
        instr_d = rd_data;
        if (rd_opcode == OpEnd) begin
          state_d = StDone;
`ifdef MCSEQ_LOOP_EN
        end else if (rd_opcode == OpRepeat) begin
          state_d = StFetch;
          if (!loop_active_q && (rpt_count != 8'd0)) begin
            loop_active_d = 1'b1;
            loop_cnt_d    = rpt_count - 8'd1;
            pc_d          = rpt_target;
          end else if (loop_active_q && (loop_cnt_q != 8'd0)) begin
            loop_cnt_d = loop_cnt_q - 8'd1;
            pc_d       = rpt_target;
          end else begin
            loop_active_d = 1'b0;
            // Falling through a REPEAT in the last word also runs off the slot.
            if (pc_q == LastPc) begin
              state_d = StDone;
              err_d   = 1'b1;
            end else begin
              pc_d = pc_q + 1'b1;
            end
          end
`endif
        end else begin
          state_d = StIssue;
        end
      end
      StIssue: begin
        if (instr_ready) begin
          if (pc_q == LastPc) begin
            state_d = StDone;
            err_d   = 1'b1;
          end else begin
            pc_d    = pc_q + 1'b1;
            state_d = StFetch;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // A handshake in the abort cycle has already been counted above.
    if (abort && (state_q != StIdle)) begin
      state_d = StIdle;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      slot_q   <= '0;
      pc_q     <= '0;
      instr_q  <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
      wr_err_q <= 1'b0;
`ifdef MCSEQ_LOOP_EN
      loop_active_q <= 1'b0;
      loop_cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      slot_q   <= slot_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
      wr_err_q <= wr_block;
`ifdef MCSEQ_LOOP_EN
      loop_active_q <= loop_active_d;
      loop_cnt_q    <= loop_cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_microcode_sequencer.sv
// Self-checking bench for microcode_sequencer: directed scenarios plus random programs
// compared against a program-walking reference model.
module tb_microcode_sequencer;
  import qc_ucode_pkg::*;

  localparam int NP = 8;
  localparam int PD = 64;
  localparam int PW = 3;
  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [PW-1:0] wr_prog;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic          wr_err;
  logic          start;
  logic [PW-1:0] prog_id;
  logic          abort;
  logic          busy;
  logic          done;
  logic          err;
  logic          instr_valid;
  logic          instr_ready;
  logic [31:0]   instr_data;
  logic [AW-1:0] instr_pc;
  logic [15:0]   issue_cnt;

  int checks = 0;
  int errors = 0;

  logic [31:0] mdl [NP][PD];
  logic [31:0] exp_data [$];
  int          exp_pc [$];

  always #5 clk = ~clk;

  microcode_sequencer #(
    .NUM_PROGS  (NP),
    .PROG_DEPTH (PD)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .wr_prog     (wr_prog),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_err      (wr_err),
    .start       (start),
    .prog_id     (prog_id),
    .abort       (abort),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr_data  (instr_data),
    .instr_pc    (instr_pc),
    .issue_cnt   (issue_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int slot, input int addr, input logic [31:0] d);
    wr_en   = 1'b1;
    wr_prog = PW'(slot);
    wr_addr = AW'(addr);
    wr_data = d;
    step();
    wr_en = 1'b0;
    mdl[slot][addr] = d;
  endtask

  // Walks the stored program by the architectural rules and lists the words the engine should see.
  function automatic void model_run(input int slot, output bit e_err);
    int pc;
    bit active;
    int lcnt;
    logic [31:0] w;
    pc = 0;
    active = 1'b0;
    lcnt = 0;
    e_err = 1'b0;
    exp_data.delete();
    exp_pc.delete();
    for (int steps = 0; steps < 4000; steps++) begin
      w = mdl[slot][pc];
      if (w[31:28] == 4'hF) return;
`ifdef MCSEQ_LOOP_EN
      if (w[31:28] == 4'hE) begin
        if (!active && w[11:4] != 8'd0) begin
          active = 1'b1;
          lcnt = int'(w[11:4]) - 1;
          pc = int'(w[12 +: AW]);
          continue;
        end
        if (active && lcnt != 0) begin
          lcnt--;
          pc = int'(w[12 +: AW]);
          continue;
        end
        active = 1'b0;
        if (pc == PD - 1) begin
          e_err = 1'b1;
          return;
        end
        pc++;
        continue;
      end
`endif
      exp_data.push_back(w);
      exp_pc.push_back(pc);
      if (pc == PD - 1) begin
        e_err = 1'b1;
        return;
      end
      pc++;
    end
  endfunction

  // mode 0: ready always high; 1: first issue stalled 5 cycles (with a stray start); 2: random ready.
  task automatic run_check(input int slot, input int mode, input bit with_abort, input string tag);
    bit          e_err;
    int          idx;
    int          cyc;
    int          first;
    int          stall;
    bit          done_seen;
    bit          hold;
    logic [31:0] hd;
    logic [AW-1:0] hp;
    model_run(slot, e_err);
    start       = 1'b1;
    abort       = with_abort;
    prog_id     = PW'(slot);
    instr_ready = 1'b0;
    step();
    start = 1'b0;
    abort = 1'b0;
    cyc = 1;
    idx = 0;
    first = -1;
    stall = 0;
    done_seen = 1'b0;
    hold = 1'b0;
    chk({tag, " busy_after_start"}, busy, 1);
    while (!done_seen && cyc < 3000) begin
      start = 1'b0;
      if (done) begin
        done_seen = 1'b1;
      end else begin
        if (hold) begin
          chk({tag, " hold_valid"}, instr_valid, 1);
          chk({tag, " hold_data"}, instr_data, hd);
          chk({tag, " hold_pc"}, instr_pc, hp);
        end
        if (instr_valid) begin
          if (first < 0) first = cyc;
          case (mode)
            0:       instr_ready = 1'b1;
            1:       instr_ready = (idx != 0) || (stall >= 5);
            default: instr_ready = ($urandom_range(0, 2) != 0);
          endcase
          if (mode == 1 && idx == 0) begin
            if (stall == 2) begin
              start   = 1'b1;
              prog_id = PW'(slot + 1);
            end
            stall++;
          end
          if (instr_ready) begin
            if (idx < exp_data.size()) begin
              chk({tag, " issue_data"}, instr_data, exp_data[idx]);
              chk({tag, " issue_pc"}, instr_pc, exp_pc[idx]);
            end else begin
              chk({tag, " extra_issue"}, idx, exp_data.size());
            end
            idx++;
            hold = 1'b0;
          end else begin
            hold = 1'b1;
            hd = instr_data;
            hp = instr_pc;
          end
        end else begin
          instr_ready = 1'($urandom_range(0, 1));
          hold = 1'b0;
        end
        step();
        cyc++;
      end
    end
    instr_ready = 1'b0;
    chk({tag, " done_seen"}, done_seen, 1);
    if (mode == 0 && exp_data.size() > 0) chk({tag, " first_valid_latency"}, first, 3);
    chk({tag, " issue_total"}, idx, exp_data.size());
    chk({tag, " err"}, err, e_err);
    chk({tag, " issue_cnt"}, issue_cnt, exp_data.size());
    chk({tag, " busy_at_done"}, busy, 0);
    chk({tag, " valid_at_done"}, instr_valid, 0);
    step();
    chk({tag, " done_pulse_end"}, done, 0);
    chk({tag, " issue_cnt_hold"}, issue_cnt, exp_data.size());
  endtask

  initial begin
    logic [31:0] w;
    int          len;
    int          rpos;
    int          slot;
    bit          seen;

    rst = 1'b1;
    wr_en = 1'b0;
    wr_prog = '0;
    wr_addr = '0;
    wr_data = '0;
    start = 1'b0;
    prog_id = '0;
    abort = 1'b0;
    instr_ready = 1'b0;
    for (int s = 0; s < NP; s++) for (int a = 0; a < PD; a++) mdl[s][a] = 32'h0;
    repeat (3) step();
    rst = 1'b0;

    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset err", err, 0);
    chk("reset valid", instr_valid, 0);
    chk("reset data", instr_data, 0);
    chk("reset pc", instr_pc, 0);
    chk("reset cnt", issue_cnt, 0);
    chk("reset wr_err", wr_err, 0);

    // Basic program, free-flowing and then with a stalled first issue.
    wr(2, 0, pack_instr(OpH, 4'd0, 4'd0, 16'h0));
    wr(2, 1, pack_instr(OpCnot, 4'd1, 4'd0, 16'h0));
    wr(2, 2, pack_instr(OpEnd, 4'd0, 4'd0, 16'h0));
    run_check(2, 0, 1'b0, "basic");
    chk("basic cnt_const", issue_cnt, 2);
    run_check(2, 1, 1'b0, "stall");

    // Slot 0 full of NOPs without END runs off the end.
    for (int a = 0; a < PD; a++) wr(0, a, pack_instr(OpNop, 4'd0, 4'd0, 16'(a)));
    run_check(0, 0, 1'b0, "nops");
    chk("nops cnt_const", issue_cnt, PD);

    // Loop program: H, X, REPEAT tgt=1 cnt=2, END.
    wr(4, 0, pack_instr(OpH, 4'd0, 4'd0, 16'h0));
    wr(4, 1, pack_instr(OpX, 4'd0, 4'd0, 16'h0));
    wr(4, 2, pack_repeat(8'd1, 8'd2));
    wr(4, 3, pack_instr(OpEnd, 4'd0, 4'd0, 16'h0));
    run_check(4, 0, 1'b0, "loop");
`ifdef MCSEQ_LOOP_EN
    chk("loop cnt_const", issue_cnt, 4);
`else
    chk("loop cnt_const", issue_cnt, 3);
`endif

    // Abort while stalled in issue.
    start = 1'b1;
    prog_id = 3'd2;
    instr_ready = 1'b0;
    step();
    start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (instr_valid) seen = 1'b1;
      else step();
    end
    chk("abort valid_reached", seen, 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort valid_drop", instr_valid, 0);
    chk("abort busy_drop", busy, 0);
    chk("abort no_done", done, 0);
    step();
    chk("abort no_done_later", done, 0);
    run_check(2, 0, 1'b0, "after_abort");

    // Write protection of the running slot.
    for (int a = 0; a < 6; a++) wr(1, a, pack_instr(opcode_e'($urandom_range(1, 7)), 4'(a), 4'd2, 16'(a)));
    wr(1, 6, pack_instr(OpEnd, 4'd0, 4'd0, 16'h0));
    for (int a = 0; a < 5; a++) wr(3, a, pack_instr(OpZ, 4'(a), 4'd0, 16'h0));
    wr(3, 6, pack_instr(OpEnd, 4'd0, 4'd0, 16'h0));
    start = 1'b1;
    prog_id = 3'd1;
    instr_ready = 1'b0;
    step();
    start = 1'b0;
    wr_en = 1'b1;
    wr_prog = 3'd1;
    wr_addr = 6'd0;
    wr_data = 32'hDEAD_BEE0;
    step();
    chk("wprot wr_err_pulse", wr_err, 1);
    wr_prog = 3'd3;
    wr_addr = 6'd5;
    wr_data = pack_instr(OpSwap, 4'd3, 4'd4, 16'h1234);
    mdl[3][5] = wr_data;
    step();
    wr_en = 1'b0;
    chk("wprot other_slot_ok", wr_err, 0);
    chk("wprot still_busy", busy, 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    run_check(1, 0, 1'b0, "wprot_slot1");
    run_check(3, 0, 1'b0, "wprot_slot3");

    // Random programs with random back-pressure.
    for (int it = 0; it < 6; it++) begin
      slot = $urandom_range(0, NP - 1);
      len = $urandom_range(2, 14);
      rpos = $urandom_range(1, len - 1);
      for (int a = 0; a < len; a++) begin
        if (a == rpos && ($urandom_range(0, 1) == 1))
          w = pack_repeat(8'($urandom_range(0, a - 1)), 8'($urandom_range(0, 3)));
        else
          w = pack_instr(opcode_e'($urandom_range(0, 7)), 4'($urandom), 4'($urandom),
                         16'($urandom));
        wr(slot, a, w);
      end
      wr(slot, len, pack_instr(OpEnd, 4'd0, 4'd0, 16'h0));
      run_check(slot, 2, (it == 3), $sformatf("rand%0d", it));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
